// File: rtl/decoder.sv
// Optical line receiver: recovers fixed-format frames (start, FRAME_SIZE data bits MSB first, stop)
// from an oversampled photodetector level and presents them with irq/error/overrun flags.
`ifndef FRAME_SIZE
`define FRAME_SIZE 16
`endif

module decoder #(
    parameter int FRAME_SIZE = `FRAME_SIZE,
    parameter int BIT_PERIOD = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sensor,
    input  logic                  ack,
    output logic [FRAME_SIZE-1:0] data,
    output logic                  irq,
    output logic                  error,
    output logic                  overrun
);

    localparam int HALF  = BIT_PERIOD / 2;
    localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IDX_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(FRAME_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_LOW
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [FRAME_SIZE-1:0]   shift_reg, shift_next;
    logic [FRAME_SIZE-1:0]   data_reg, data_next;
    logic                    irq_reg, irq_next;
    logic                    error_reg, error_next;
    logic                    overrun_reg, overrun_next;
    logic                    sync1_reg;
    logic                    sensor_s;
    logic                    frame_good;
    logic                    frame_bad;

    // Two-flop synchronizer: the raw level is asynchronous to clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sensor_s  <= 1'b0;
        end else begin
            sync1_reg <= sensor;
            sensor_s  <= sync1_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        frame_good = 1'b0;
        frame_bad  = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sensor_s) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    // Re-check at mid start bit so single-clock glitches are ignored.
                    if (cnt_reg == CNT_HALF_LAST) begin
                        cnt_next = '0;
                        if (sensor_s) begin
                            state_next = DATA;
                            idx_next   = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_reg == CNT_BIT_LAST) begin
                        shift_next = {shift_reg[FRAME_SIZE-2:0], sensor_s};
                        cnt_next   = '0;
                        idx_next   = idx_reg + IDX_ONE;
                        if (idx_reg == IDX_LAST) begin
                            state_next = STOP;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_reg == CNT_BIT_LAST) begin
                        cnt_next = '0;
                        if (!sensor_s) begin
                            frame_good = 1'b1;
                            state_next = IDLE;
                        end else begin
                            frame_bad  = 1'b1;
                            state_next = WAIT_LOW;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    // A line stuck high must not be re-framed; wait for idle first.
                    if (!sensor_s) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Flag/data update: a completion in the same cycle as ack takes precedence.
    always_comb begin
        data_next    = data_reg;
        irq_next     = irq_reg;
        error_next   = error_reg;
        overrun_next = overrun_reg;

        if (frame_good) begin
            if (irq_reg && !ack) begin
                overrun_next = 1'b1;
            end else begin
                data_next = shift_reg;
                irq_next  = 1'b1;
                if (ack) begin
                    error_next   = 1'b0;
                    overrun_next = 1'b0;
                end
            end
        end else if (frame_bad) begin
            error_next = 1'b1;
            if (ack) begin
                irq_next     = 1'b0;
                overrun_next = 1'b0;
            end
        end else if (ack) begin
            irq_next     = 1'b0;
            error_next   = 1'b0;
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            irq_reg     <= 1'b0;
            error_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            irq_reg     <= irq_next;
            error_reg   <= error_next;
            overrun_reg <= overrun_next;
        end
    end

    assign data    = data_reg;
    assign irq     = irq_reg;
    assign error   = error_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: a frame-level model predicts data and flags at each
// frame completion edge; outputs are compared against it on every falling edge.
module tb_decoder;

    localparam int FRAME_SIZE = 16;
    localparam int BIT_PERIOD = 4;
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int LATENCY    = 2 + HALF + 17 * BIT_PERIOD;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b0;
    logic                  sensor = 1'b0;
    logic                  ack = 1'b0;
    logic [FRAME_SIZE-1:0] data;
    logic                  irq;
    logic                  error;
    logic                  overrun;

    decoder #(
        .FRAME_SIZE(FRAME_SIZE),
        .BIT_PERIOD(BIT_PERIOD)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .sensor (sensor),
        .ack    (ack),
        .data   (data),
        .irq    (irq),
        .error  (error),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                    edge_no;
        bit                    is_err;
        logic [FRAME_SIZE-1:0] val;
    } comp_t;

    int                    n_tests = 0;
    int                    n_fail = 0;
    int                    cyc = 0;
    bit                    check_on = 1'b0;
    comp_t                 pending[$];
    logic [FRAME_SIZE-1:0] m_data = '0;
    logic                  m_irq = 1'b0;
    logic                  m_err = 1'b0;
    logic                  m_ovr = 1'b0;
    int                    err_rises = 0;
    logic                  err_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: at a frame's completion edge apply the receive rules, otherwise ack clears.
    initial begin
        comp_t c;
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
            if (reset) begin
                m_data = '0;
                m_irq  = 1'b0;
                m_err  = 1'b0;
                m_ovr  = 1'b0;
                pending.delete();
            end else begin
                if (!enable) pending.delete();
                if (pending.size() > 0 && pending[0].edge_no == cyc) begin
                    c = pending.pop_front();
                    if (c.is_err) begin
                        m_err = 1'b1;
                        if (ack) begin
                            m_irq = 1'b0;
                            m_ovr = 1'b0;
                        end
                    end else if (m_irq && !ack) begin
                        m_ovr = 1'b1;
                    end else begin
                        m_data = c.val;
                        m_irq  = 1'b1;
                        if (ack) begin
                            m_err = 1'b0;
                            m_ovr = 1'b0;
                        end
                    end
                end else if (ack) begin
                    m_irq = 1'b0;
                    m_err = 1'b0;
                    m_ovr = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (check_on) begin
                check("cyc_data", data, m_data);
                check("cyc_irq", irq, m_irq);
                check("cyc_error", error, m_err);
                check("cyc_overrun", overrun, m_ovr);
                if (error === 1'b1 && err_prev !== 1'b1) err_rises++;
            end
            err_prev = error;
        end
    end

    task automatic drive_bit(input logic v);
        sensor = v;
        repeat (BIT_PERIOD) @(negedge clock);
    endtask

    // Called on a falling edge; returns on the falling edge just before edge start+18*BIT_PERIOD.
    task automatic send_frame(input logic [FRAME_SIZE-1:0] val, input logic stop_v, output int comp);
        comp_t c;
        comp         = cyc + 1 + LATENCY;
        c.edge_no    = comp;
        c.is_err     = stop_v;
        c.val        = val;
        pending.push_back(c);
        $display("[TB] frame %h stop=%0b start_edge=%0d done_edge=%0d", val, stop_v, cyc + 1, comp);
        drive_bit(1'b1);
        for (int i = FRAME_SIZE - 1; i >= 0; i--) drive_bit(val[i]);
        drive_bit(stop_v);
    endtask

    task automatic send_partial(input logic [FRAME_SIZE-1:0] val, input int nbits);
        $display("[TB] partial frame %h bits=%0d start_edge=%0d", val, nbits, cyc + 1);
        drive_bit(1'b1);
        for (int i = 0; i < nbits; i++) drive_bit(val[FRAME_SIZE-1-i]);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
    endtask

    initial begin
        int comp;
        int comp2;

        reset  = 1'b1;
        enable = 1'b1;
        sensor = 1'b0;
        ack    = 1'b0;
        repeat (3) @(negedge clock);
        reset    = 1'b0;
        check_on = 1'b1;
        check("reset_data", data, 32'h0);
        check("reset_irq", irq, 32'h0);
        check("reset_error", error, 32'h0);
        check("reset_overrun", overrun, 32'h0);

        // Single-clock glitch
        $display("[TB] glitch pulse at edge %0d", cyc + 1);
        sensor = 1'b1;
        @(negedge clock);
        sensor = 1'b0;
        repeat (12) @(negedge clock);
        check("glitch_irq", irq, 32'h0);
        check("glitch_error", error, 32'h0);
        check("glitch_data", data, 32'h0);

        // Nominal frame: irq first visible after edge 72
        send_frame(16'h4FB6, 1'b0, comp);
        check("nom_irq_edge71", irq, 32'h0);
        @(negedge clock);
        check("nom_irq_edge72", irq, 32'h1);
        check("nom_data", data, 32'h4FB6);
        check("nom_error", error, 32'h0);
        check("nom_overrun", overrun, 32'h0);
        pulse_ack();
        repeat (4) @(negedge clock);

        // Framing error, line stuck high afterwards
        err_rises = 0;
        send_frame(16'hA5A5, 1'b1, comp);
        @(negedge clock);
        check("ferr_error", error, 32'h1);
        check("ferr_data", data, 32'h4FB6);
        check("ferr_irq", irq, 32'h0);
        pulse_ack();
        repeat (18) @(negedge clock);
        sensor = 1'b0;
        repeat (10) @(negedge clock);
        check("ferr_once", err_rises, 32'h1);
        send_frame(16'h0001, 1'b0, comp);
        @(negedge clock);
        check("ferr_next_data", data, 32'h0001);
        check("ferr_next_irq", irq, 32'h1);
        pulse_ack();
        repeat (4) @(negedge clock);

        // Back-to-back frames without ack: second is lost
        send_frame(16'h1234, 1'b0, comp);
        send_frame(16'h5678, 1'b0, comp2);
        repeat (2) @(negedge clock);
        check("ovr_data", data, 32'h1234);
        check("ovr_overrun", overrun, 32'h1);
        check("ovr_irq", irq, 32'h1);
        repeat (4) @(negedge clock);

        // ack coinciding with completion
        send_frame(16'h9ABC, 1'b0, comp);
        for (int k = 0; k < 2 * BIT_PERIOD && cyc + 1 < comp; k++) @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        check("same_data", data, 32'h9ABC);
        check("same_irq", irq, 32'h1);
        check("same_overrun", overrun, 32'h0);
        pulse_ack();
        repeat (4) @(negedge clock);

        // enable dropped after 8 data bits
        send_partial(16'hC3C3, 8);
        enable = 1'b0;
        sensor = 1'b0;
        repeat (4) @(negedge clock);
        enable = 1'b1;
        repeat (90) @(negedge clock);
        check("abort_irq", irq, 32'h0);
        check("abort_data", data, 32'h9ABC);

        // reset mid-frame
        send_partial(16'h8001, 6);
        reset  = 1'b1;
        sensor = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (90) @(negedge clock);
        check("rst_irq", irq, 32'h0);
        check("rst_data", data, 32'h0);

        send_frame(16'hFFFF, 1'b0, comp);
        @(negedge clock);
        check("post_rst_data", data, 32'hFFFF);
        check("post_rst_irq", irq, 32'h1);
        check("post_rst_error", error, 32'h0);
        check("post_rst_overrun", overrun, 32'h0);
        repeat (4) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
